// File: rtl/alu_drv_pkg.sv
// alu_cmd_driver shared definitions: FSM encoding, ALU opcodes, SW bit map.
// Build option ALU_DRV_FLAGS_EN enables the flag read-back phase.
package alu_drv_pkg;

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_LD_A   = 4'd1;
   localparam logic [3:0] ST_GAP_A  = 4'd2;
   localparam logic [3:0] ST_LD_B   = 4'd3;
   localparam logic [3:0] ST_GAP_B  = 4'd4;
   localparam logic [3:0] ST_LD_OP  = 4'd5;
   localparam logic [3:0] ST_GAP_OP = 4'd6;
   localparam logic [3:0] ST_RD_RES = 4'd7;
   localparam logic [3:0] ST_RD_FLG = 4'd8;
   localparam logic [3:0] ST_RESP   = 4'd9;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_XOR = 3'd2;
   localparam logic [2:0] OP_NOR = 3'd3;
   localparam logic [2:0] OP_ADD = 3'd4;
   localparam logic [2:0] OP_SUB = 3'd5;
   localparam logic [2:0] OP_SLT = 3'd6;
   localparam logic [2:0] OP_SLL = 3'd7;

   localparam int SW_LD_A     = 1;
   localparam int SW_LD_B     = 2;
   localparam int SW_LD_OP    = 3;
   localparam int SW_SHOW_RES = 4;
   localparam int SW_SHOW_FLG = 5;

endpackage

// File: rtl/alu_drv_timer.sv
// alu_drv_timer: loadable down-counter; done is high while the count is zero.
// Loading N gives a phase of N+1 cycles ending on the done cycle.
module alu_drv_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt_q, cnt_d;

   // reload on phase entry, otherwise count down and hold at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: replays one (A, B, op) command onto the ALU switch bus.
// Define ALU_DRV_FLAGS_EN to read back {OF, ZF} after the result.
module alu_cmd_driver
   import alu_drv_pkg::*;
#(
   parameter int STROBE_LEN = 2,
   parameter int SETTLE     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   input  logic [2:0]  cmd_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic [1:0]  rsp_flags,
   output logic [5:1]  alu_sw,
   output logic [31:0] alu_data_o,
   input  logic [31:0] alu_data_i
);

   localparam int MAXLEN = (STROBE_LEN > SETTLE) ? STROBE_LEN : SETTLE;
   localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
   localparam logic [CW-1:0] L_M1 = CW'(STROBE_LEN - 1);
   localparam logic [CW-1:0] S_M1 = CW'(SETTLE - 1);

   logic [3:0]    state_q, state_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;
   logic [2:0]    op_q, op_d;
   logic [31:0]   res_q, res_d;
   logic          tmr_load;
   logic [CW-1:0] tmr_val;
   logic          tmr_done;

   alu_drv_timer #(.W(CW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

`ifdef ALU_DRV_FLAGS_EN
   logic [1:0] flg_q, flg_d;
`endif

   // phase sequencing, command capture and read-back sampling
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      res_d    = res_q;
      tmr_load = 1'b0;
      tmr_val  = L_M1;
`ifdef ALU_DRV_FLAGS_EN
      flg_d    = flg_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               a_d      = cmd_a;
               b_d      = cmd_b;
               op_d     = cmd_op;
               state_d  = ST_LD_A;
               tmr_load = 1'b1;
            end
         end
         ST_LD_A: if (tmr_done) begin
            state_d = ST_GAP_A; tmr_load = 1'b1;
         end
         ST_GAP_A: if (tmr_done) begin
            state_d = ST_LD_B; tmr_load = 1'b1;
         end
         ST_LD_B: if (tmr_done) begin
            state_d = ST_GAP_B; tmr_load = 1'b1;
         end
         ST_GAP_B: if (tmr_done) begin
            state_d = ST_LD_OP; tmr_load = 1'b1;
         end
         ST_LD_OP: if (tmr_done) begin
            state_d = ST_GAP_OP; tmr_load = 1'b1;
         end
         ST_GAP_OP: if (tmr_done) begin
            state_d  = ST_RD_RES;
            tmr_load = 1'b1;
            tmr_val  = S_M1;
         end
         ST_RD_RES: if (tmr_done) begin
            res_d = alu_data_i;
`ifdef ALU_DRV_FLAGS_EN
            state_d  = ST_RD_FLG;
            tmr_load = 1'b1;
            tmr_val  = S_M1;
`else
            state_d  = ST_RESP;
`endif
         end
`ifdef ALU_DRV_FLAGS_EN
         ST_RD_FLG: if (tmr_done) begin
            flg_d   = alu_data_i[1:0];
            state_d = ST_RESP;
         end
`endif
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
      end
   end

`ifdef ALU_DRV_FLAGS_EN
   // captured flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flg_q <= '0;
      else        flg_q <= flg_d;
   end
   assign rsp_flags = flg_q;
`else
   assign rsp_flags = 2'b00;
`endif

   // switch strobes and data bus decoded purely from state
   always_comb begin
      alu_sw     = '0;
      alu_data_o = '0;
      unique case (state_q)
         ST_LD_A:   begin alu_sw[SW_LD_A] = 1'b1; alu_data_o = a_q; end
         ST_GAP_A:  alu_data_o = a_q;
         ST_LD_B:   begin alu_sw[SW_LD_B] = 1'b1; alu_data_o = b_q; end
         ST_GAP_B:  alu_data_o = b_q;
         ST_LD_OP:  begin
            alu_sw[SW_LD_OP] = 1'b1;
            alu_data_o       = {29'd0, op_q};
         end
         ST_GAP_OP: alu_data_o = {29'd0, op_q};
         ST_RD_RES: alu_sw[SW_SHOW_RES] = 1'b1;
`ifdef ALU_DRV_FLAGS_EN
         ST_RD_FLG: alu_sw[SW_SHOW_FLG] = 1'b1;
`endif
         default: ;
      endcase
   end

   assign cmd_ready  = (state_q == ST_IDLE);
   assign rsp_valid  = (state_q == ST_RESP);
   assign rsp_result = res_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver against a behavioural ALU top.
// Honours ALU_DRV_FLAGS_EN for expected latency and flags.
module tb_alu_cmd_driver;
   import alu_drv_pkg::*;

   localparam int L = 2;
   localparam int S = 2;
`ifdef ALU_DRV_FLAGS_EN
   localparam int  EXP_LAT = 6*L + 2*S + 1;
   localparam bit  FLG_ON  = 1'b1;
`else
   localparam int  EXP_LAT = 6*L + S + 1;
   localparam bit  FLG_ON  = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_a = '0;
   logic [31:0] cmd_b = '0;
   logic [2:0]  cmd_op = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_result;
   logic [1:0]  rsp_flags;
   logic [5:1]  alu_sw;
   logic [31:0] alu_data_o;
   logic [31:0] alu_data_i;

   int n_tests = 0;
   int n_fail  = 0;
   logic [5:1] swlog [0:64];

   always #5 clk = ~clk;

   alu_cmd_driver #(.STROBE_LEN(L), .SETTLE(S)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_op     (cmd_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .alu_sw     (alu_sw),
      .alu_data_o (alu_data_o),
      .alu_data_i (alu_data_i)
   );

   // behavioural switch-controlled ALU top
   logic [31:0] m_a = '0;
   logic [31:0] m_b = '0;
   logic [2:0]  m_op = '0;
   logic [31:0] m_res;
   logic        m_of;

   always @(posedge clk) begin
      if (alu_sw[1]) m_a <= alu_data_o;
      if (alu_sw[2]) m_b <= alu_data_o;
      if (alu_sw[3]) m_op <= alu_data_o[2:0];
   end

   always_comb begin
      m_res = '0;
      m_of  = 1'b0;
      case (m_op)
         OP_AND: m_res = m_a & m_b;
         OP_OR:  m_res = m_a | m_b;
         OP_XOR: m_res = m_a ^ m_b;
         OP_NOR: m_res = ~(m_a | m_b);
         OP_ADD: begin
            m_res = m_a + m_b;
            m_of  = (m_a[31] == m_b[31]) && (m_res[31] != m_a[31]);
         end
         OP_SUB: begin
            m_res = m_a - m_b;
            m_of  = (m_a[31] != m_b[31]) && (m_res[31] != m_a[31]);
         end
         OP_SLT: m_res = {31'd0, $signed(m_a) < $signed(m_b)};
         default: m_res = m_b << m_a[4:0];
      endcase
   end

   assign alu_data_i = alu_sw[4] ? m_res :
                       alu_sw[5] ? {30'd0, m_of, (m_res == 32'd0)} :
                       32'd0;

   // strobes must be one-hot or idle every cycle
   always @(negedge clk) begin
      if (rst_n) begin
         n_tests++;
         if (!$onehot0(alu_sw)) begin
            n_fail++;
            $display("FAIL sw_onehot: alu_sw=%b", alu_sw);
         end
      end
   end

   task automatic launch(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
      @(negedge clk);
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      @(posedge clk);
   endtask

   task automatic collect(output int lat);
      lat = -1;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         swlog[k] = alu_sw;
         if (rsp_valid) begin
            lat = k;
            break;
         end
      end
      n_tests++;
      if (lat != EXP_LAT) begin
         n_fail++;
         $display("FAIL latency: got %0d want %0d", lat, EXP_LAT);
      end
   endtask

   task automatic ack_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic chk_rsp(input string nm, input logic [31:0] er,
                          input logic [1:0] ef);
      logic [1:0] ef_m;
      ef_m = FLG_ON ? ef : 2'b00;
      n_tests++;
      if (rsp_result !== er) begin
         n_fail++;
         $display("FAIL %s result: got %h want %h", nm, rsp_result, er);
      end
      n_tests++;
      if (rsp_flags !== ef_m) begin
         n_fail++;
         $display("FAIL %s flags: got %b want %b", nm, rsp_flags, ef_m);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({cmd_ready, rsp_valid, rsp_flags, alu_sw} !== 9'b1_0_00_00000
          || rsp_result !== 32'd0 || alu_data_o !== 32'd0) begin
         n_fail++;
         $display("FAIL reset: rdy=%b vld=%b res=%h flg=%b sw=%b d=%h",
                  cmd_ready, rsp_valid, rsp_result, rsp_flags,
                  alu_sw, alu_data_o);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_op(input string nm, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] op,
                          input logic [31:0] er, input logic [1:0] ef);
      int lat;
      launch(a, b, op);
      collect(lat);
      chk_rsp(nm, er, ef);
      ack_rsp();
   endtask

   task automatic test_sll_windows();
      int lat;
      logic [5:1] e;
      launch(32'd4, 32'hFFFF_FFFF, OP_SLL);
      collect(lat);
      chk_rsp("sll", 32'hFFFF_FFF0, 2'b00);
      for (int k = 1; k <= EXP_LAT; k++) begin
         e = '0;
         if (k >= 1 && k <= L)           e[1] = 1'b1;
         if (k >= 2*L+1 && k <= 3*L)     e[2] = 1'b1;
         if (k >= 4*L+1 && k <= 5*L)     e[3] = 1'b1;
         if (k >= 6*L+1 && k <= 6*L+S)   e[4] = 1'b1;
         if (FLG_ON && k >= 6*L+S+1 && k <= 6*L+2*S) e[5] = 1'b1;
         n_tests++;
         if (swlog[k] !== e) begin
            n_fail++;
            $display("FAIL sw_window c%0d: got %b want %b", k, swlog[k], e);
         end
      end
      ack_rsp();
   endtask

   task automatic test_back_to_back();
      int lat;
      launch(32'h0001_FFFF, 32'h0001_000F, OP_OR);
      collect(lat);
      cmd_a = 32'hFFF1_FFFF; cmd_b = 32'h0001_000F;
      cmd_op = OP_ADD; cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_tests++;
         if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0
             || rsp_result !== 32'h0001_FFFF) begin
            n_fail++;
            $display("FAIL hold c%0d: vld=%b rdy=%b res=%h", i,
                     rsp_valid, cmd_ready, rsp_result);
         end
      end
      ack_rsp();
      n_tests++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL after_ack: vld=%b rdy=%b want 0 1",
                  rsp_valid, cmd_ready);
      end
      @(posedge clk);
      collect(lat);
      chk_rsp("b2b_add", 32'hFFF3_000E, 2'b00);
      ack_rsp();
   endtask

   task automatic test_mid_reset();
      launch(32'h1234_5678, 32'h9ABC_DEF0, OP_AND);
      for (int k = 1; k <= 2*L+1; k++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
      end
      n_tests++;
      if (alu_sw !== 5'b00010) begin
         n_fail++;
         $display("FAIL in_ld_b: alu_sw=%b want 00010", alu_sw);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (alu_sw !== 5'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0
          || alu_data_o !== 32'd0) begin
         n_fail++;
         $display("FAIL mid_reset: sw=%b rdy=%b vld=%b d=%h",
                  alu_sw, cmd_ready, rsp_valid, alu_data_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      test_op("xor", 32'h0001_FFFF, 32'h0001_000F, OP_XOR,
              32'h0000_FFF0, 2'b00);
   endtask

   initial begin
      test_reset();
      test_op("and", 32'h0001_FFFF, 32'h0001_000F, OP_AND,
              32'h0001_000F, 2'b00);
      test_op("add", 32'hFFF1_FFFF, 32'h0001_000F, OP_ADD,
              32'hFFF3_000E, 2'b00);
      test_op("sub", 32'h0001_FFFF, 32'hFFF1_000F, OP_SUB,
              32'h0010_FFF0, 2'b00);
      test_op("sub_zero", 32'h0000_1234, 32'h0000_1234, OP_SUB,
              32'h0000_0000, 2'b01);
      test_op("add_of", 32'h7FFF_FFFF, 32'h0000_0001, OP_ADD,
              32'h8000_0000, 2'b10);
      test_op("slt", 32'hFFFF_FFFE, 32'h0000_0003, OP_SLT,
              32'h0000_0001, 2'b00);
      test_sll_windows();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
